// File: rtl/prach_pkg.sv
// rtl/prach_pkg.sv - shared widths, sample type and round/saturate helper for the PRACH mixer
package prach_pkg;

  localparam int NumChn      = 8;
  localparam int ChnWidth    = 8;
  localparam int SampleWidth = 16;
  localparam int NcoFracBits = 14;

  localparam int ProdWidth   = 2 * SampleWidth;
  localparam int SumWidth    = ProdWidth + 1;
  // spare(1) + sync(1) + dv(1) + chn(8) + q(16) + i(16)
  localparam int AlignWidth  = 43;

  localparam int SampleMax   = (2 ** (SampleWidth - 1)) - 1;
  localparam int SampleMin   = -(2 ** (SampleWidth - 1));

  typedef logic signed [SampleWidth-1:0] sample_t;

  // Round half up at the Q2.14 binary point, then clamp or wrap to a Q1.15 sample
  function automatic sample_t round_sat(input logic signed [SumWidth-1:0] sum,
                                        input logic                       sat_en);
    logic signed [SumWidth-1:0] rnd;
    logic signed [SumWidth-1:0] r;
    logic signed [SumWidth-1:0] max_v;
    logic signed [SumWidth-1:0] min_v;
    rnd   = SumWidth'(1 << (NcoFracBits - 1));
    max_v = SumWidth'(SampleMax);
    min_v = SumWidth'(SampleMin);
    r     = (sum + rnd) >>> NcoFracBits;
    if (sat_en && (r > max_v)) begin
      r = max_v;
    end else if (sat_en && (r < min_v)) begin
      r = min_v;
    end
    return r[SampleWidth-1:0];
  endfunction

endpackage

// File: rtl/prach_mixer_delay.sv
// rtl/prach_mixer_delay.sv - fixed-length register delay line, cleared by reset
module prach_mixer_delay #(
  parameter int WIDTH = 1,
  parameter int DELAY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DELAY == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] pipe [DELAY];

      // Shift one stage per clock; reset empties the whole line
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < DELAY; s++) begin
            pipe[s] <= '0;
          end
        end else begin
          pipe[0] <= din;
          for (int s = 1; s < DELAY; s++) begin
            pipe[s] <= pipe[s-1];
          end
        end
      end

      assign dout = pipe[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/prach_mixer.sv
// rtl/prach_mixer.sv - TDM complex mixer: aligns samples to the NCO, multiplies, rounds, saturates
// Optional feature macro: PRACH_MIXER_ERR_CNT_EN adds the align_err_cnt output.
module prach_mixer
  import prach_pkg::*;
#(
  parameter int NcoLatency = 4,
  parameter bit SatEn      = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SampleWidth-1:0] din_i,
  input  logic [SampleWidth-1:0] din_q,
  input  logic                   din_dv,
  input  logic [ChnWidth-1:0]    din_chn,
  input  logic                   sync_in,
  input  logic [SampleWidth-1:0] nco_cos,
  input  logic [SampleWidth-1:0] nco_sin,
  input  logic                   nco_dv,
  input  logic [ChnWidth-1:0]    nco_chn,
  output logic [SampleWidth-1:0] dout_i,
  output logic [SampleWidth-1:0] dout_q,
  output logic                   dout_dv,
  output logic [ChnWidth-1:0]    dout_chn,
  output logic                   sync_out,
`ifdef PRACH_MIXER_ERR_CNT_EN
  output logic [15:0]            align_err_cnt,
`endif
  output logic                   align_err
);

  // Alignment stage: the sample is delayed to meet the NCO word from the same input cycle
  logic [AlignWidth-1:0] align_in;
  logic [AlignWidth-1:0] align_out;
  sample_t               a_i;
  sample_t               a_q;
  logic [ChnWidth-1:0]   a_chn;
  logic                  a_dv;
  logic                  a_sync;
  logic                  unused_spare;
  sample_t               c_cos;
  sample_t               c_sin;
  logic                  mismatch;

  assign align_in = {1'b0, sync_in, din_dv, din_chn, din_q, din_i};

  prach_mixer_delay #(
    .WIDTH(AlignWidth),
    .DELAY(NcoLatency)
  ) u_align (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (align_in),
    .dout (align_out)
  );

  assign {unused_spare, a_sync, a_dv, a_chn, a_q, a_i} = align_out;
  assign c_cos = nco_cos;
  assign c_sin = nco_sin;

  // A missing/extra NCO word, or a word for another channel, means the two streams slipped
  assign mismatch = (a_dv != nco_dv) || (a_dv && nco_dv && (a_chn != nco_chn));

  // Stage 1: full-precision products
  logic signed [ProdWidth-1:0] p_ic, p_qs, p_is, p_qc;
  logic                        s1_dv, s1_sync;
  logic [ChnWidth-1:0]         s1_chn;

  // Register the four partial products together with the sample's side-band
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_ic    <= '0;
      p_qs    <= '0;
      p_is    <= '0;
      p_qc    <= '0;
      s1_dv   <= 1'b0;
      s1_sync <= 1'b0;
      s1_chn  <= '0;
    end else begin
      p_ic    <= a_i * c_cos;
      p_qs    <= a_q * c_sin;
      p_is    <= a_i * c_sin;
      p_qc    <= a_q * c_cos;
      s1_dv   <= a_dv;
      s1_sync <= a_sync;
      s1_chn  <= a_chn;
    end
  end

  // Stage 2: 33-bit sums so the worst-case product pair cannot overflow
  logic signed [SumWidth-1:0] s2_i, s2_q;
  logic                       s2_dv, s2_sync;
  logic [ChnWidth-1:0]        s2_chn;

  // Form I*cos - Q*sin and I*sin + Q*cos with sign-extended products
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_i    <= '0;
      s2_q    <= '0;
      s2_dv   <= 1'b0;
      s2_sync <= 1'b0;
      s2_chn  <= '0;
    end else begin
      s2_i    <= $signed({p_ic[ProdWidth-1], p_ic}) - $signed({p_qs[ProdWidth-1], p_qs});
      s2_q    <= $signed({p_is[ProdWidth-1], p_is}) + $signed({p_qc[ProdWidth-1], p_qc});
      s2_dv   <= s1_dv;
      s2_sync <= s1_sync;
      s2_chn  <= s1_chn;
    end
  end

  // Stage 3: round/saturate into the output registers; data holds while no sample is valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_i   <= '0;
      dout_q   <= '0;
      dout_dv  <= 1'b0;
      dout_chn <= '0;
      sync_out <= 1'b0;
    end else begin
      dout_dv  <= s2_dv;
      dout_chn <= s2_chn;
      sync_out <= s2_sync;
      if (s2_dv) begin
        dout_i <= round_sat(s2_i, SatEn);
        dout_q <= round_sat(s2_q, SatEn);
      end
    end
  end

  // Sticky error, cleared by the delayed frame sync; sync wins over a same-cycle mismatch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err <= 1'b0;
    end else if (a_sync) begin
      align_err <= 1'b0;
    end else if (mismatch) begin
      align_err <= 1'b1;
    end
  end

`ifdef PRACH_MIXER_ERR_CNT_EN
  // Count every mismatch cycle, saturating; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err_cnt <= '0;
    end else if (mismatch && (align_err_cnt != 16'hFFFF)) begin
      align_err_cnt <= align_err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/prach_mixer.md
PRACH_MIXER -- requirements
Module: prach_mixer

Interface
REQ-001 SHALL have parameter NcoLatency, default 4: cycles from the upstream NCO input (din_dv, din_chn, sync_in) to its cos/sin output.
REQ-002 SHALL have parameter SatEn, default 1: 1 saturates the outputs, 0 wraps them (two's-complement truncation).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic SHALL be on clk.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports din_i / din_q, input, 16 each: TDM sample, signed Q1.15.
REQ-006 SHALL have port din_dv, input, 1: sample valid, one per cycle.
REQ-007 SHALL have port din_chn, input, 8: channel index; bits [2:0] are used.
REQ-008 SHALL have port sync_in, input, 1: frame sync, the same pulse that drives the NCO sync.
REQ-009 SHALL have ports nco_cos / nco_sin, input, 16 each: NCO output, signed Q2.14, range -16384..16384.
REQ-010 SHALL have port nco_dv, input, 1: NCO output valid.
REQ-011 SHALL have port nco_chn, input, 8: NCO output channel index.
REQ-012 SHALL have ports dout_i / dout_q, output, 16 each: mixed sample, signed Q1.15.
REQ-013 SHALL have ports dout_dv, output, 1; dout_chn, output, 8; sync_out, output, 1.
REQ-014 SHALL have port align_err, output, 1: sticky flag for data/NCO misalignment.

Function
REQ-015 SHALL delay din_i, din_q, din_dv, din_chn and sync_in by NcoLatency cycles, so each sample meets the NCO word generated from the same input cycle.
REQ-016 SHALL compute dout_i = I*cos - Q*sin and dout_q = I*sin + Q*cos, using full-precision 32-bit products and a 33-bit sum.
REQ-017 SHALL round by adding 2^13, then arithmetic-shift right by 14.
REQ-018 With SatEn=1, SHALL clamp results to +32767 / -32768; with SatEn=0, SHALL keep the low 16 bits.
REQ-019 SHALL use a three-register pipeline after alignment (products, sums, round/saturate); the total latency from din_* to dout_* SHALL be NcoLatency+3 cycles.
REQ-020 SHALL pass dv, chn and sync through the same NcoLatency+3 delay unchanged.
REQ-021 SHALL hold dout_i / dout_q at their last value while dout_dv is low.
REQ-022 SHALL set align_err when, at the alignment stage, the delayed dv differs from nco_dv, or both are high and the delayed chn differs from nco_chn.
REQ-023 align_err SHALL stay set until the delayed sync arrives at the alignment stage; if a mismatch and the delayed sync occur in the same cycle, the flag SHALL end that cycle cleared.
REQ-024 A sync_in pulse SHALL NOT flush or alter samples already in flight.

Reset
REQ-025 While rst_n is low, SHALL asynchronously clear dout_i, dout_q, dout_dv, dout_chn, sync_out, align_err and all valid/sync pipeline bits to 0.
REQ-026 Reset mid-stream SHALL discard all in-flight samples; the first dout_dv after release SHALL come from a sample entered after release.

Configuration
REQ-027 Macro PRACH_MIXER_ERR_CNT_EN, when defined, SHALL add output align_err_cnt[15:0].
- The counter increments on each mismatch cycle, saturates at 65535, and clears on reset only.
- When the macro is undefined, the port and its logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-028 Package prach_pkg SHALL hold NumChn=8, ChnWidth=8, SampleWidth=16, NcoFracBits=14 and typedef sample_t (signed 16-bit).
REQ-029 The alignment delay SHALL be built from the codebase's existing delay sub-module (WIDTH=43, DELAY=NcoLatency); no other sub-module is needed.

Verification
REQ-030 Identity test: cos=16384, sin=0, din=(1000,-2000) on channel 3 -> dout=(1000,-2000), dout_chn=3, exactly NcoLatency+3 cycles later.
REQ-031 90-degree rotation test: cos=0, sin=16384, din=(1000,2000) -> dout=(-2000,1000).
REQ-032 Saturation test: din=(-32768,-32768), cos=sin=16384 -> dout_i=0, dout_q=-32768 (SatEn=1); dout_q=0 (SatEn=0).
REQ-033 Rounding test: din=(3,0), cos=sin=8192 -> dout=(2,2), since 1.5 rounds up.
REQ-034 Alignment test: skew nco_chn by one slot for one cycle -> align_err rises and stays high until the next delayed sync; align_err_cnt=1 when PRACH_MIXER_ERR_CNT_EN is defined.
REQ-035 Reset test: assert rst_n low during a full 8-channel stream -> all outputs are 0 immediately; no stale dout_dv appears after release.
